gearbox_256_192: RTL and testbench
==================================

# gearbox_256_192

Receive-side 4:3 gearbox and inverse of the 192→256 transmit gearbox. It takes 256-bit words from the downstream PCS side and returns 192-bit words to the upper layer. The datapath is four independent 64→48 lanes so that lane k restores exactly the bits the transmit lane k packed. A single shared controller throttles the source with an idle handshake and obeys backpressure from the sink.

## Interface
Parameters: none. Widths are fixed: 4 lanes, 16-bit unit, 9-unit lane buffer.
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_enable  in  1  global enable; low freezes the block
- in_data  in  256  input word; lane k is bits [64k+63:64k]
- in_datavalid  in  1  in_data is valid this cycle
- out_idle  out  1  to source: high means in_datavalid must be low this cycle
- out_data  out  192  output word; lane k is bits [48k+47:48k]
- out_datavalid  out  1  out_data is valid this cycle
- in_idle  in  1  from sink: high means no output may be produced
- overflow  out  1  one-cycle pulse when in_datavalid arrives while out_idle is high; that word is dropped

## Operation
- Buffer model:
  - Each lane holds up to 9 units of 16 bits. Unit 0 is the oldest.
  - One shared count (0..9) gives the number of valid units and is identical in every lane.
- Signals evaluated each cycle, all from the registered count:
  - out_idle = !in_enable || (count > 5).
  - accept = in_enable && in_datavalid && !out_idle.
  - emit = in_enable && !in_idle && (count >= 3).
- Emit: lane units 0..2 go into the lane's output register, unit 0 in bits [15:0]. The remaining units shift down by 3.
- Accept: the 4 input units (in_data lane bits [15:0] is the first unit) are written at unit index (count − 3·emit).
- Count update: count_next = count − 3·emit + 4·accept. The bound count_next ≤ 9 follows from the out_idle rule, so no saturation logic is needed.
- Rejected input: in_datavalid while out_idle is high sets overflow for the next cycle only. Buffer and count are unchanged.
- in_enable low:
  - No accept and no emit.
  - Buffer and count are held.
  - out_datavalid is 0.
  - out_data holds its last value.
- Reset values: count 0; buffers 0; out_data 0; out_datavalid 0; overflow 0. out_idle = !in_enable.
- Reset asserted mid-operation discards all buffered data. After release, the first accepted word realigns at unit 0.

## Timing
- out_data and out_datavalid are registered and reflect the emit decision of the previous cycle.
- Latency: a word accepted in cycle t gives its first output bits with out_datavalid high in cycle t+2.
- out_idle has no combinational path from in_datavalid or in_idle.
- Steady state, sink never idle:
  - count cycles 4→5→6→3→4.
  - out_idle is high 1 cycle in 4.
  - out_datavalid is continuously high, so 3 inputs produce 4 outputs.
- Backpressure: with in_idle held high, count climbs to ≤9 and out_idle stays high until count ≤ 5. When in_idle falls, output resumes the next cycle with no data loss.
- Simultaneous accept and emit in one cycle is the normal case. The write index uses the post-shift position.

## Structure
- Shared package holds:
  - GB_UNIT_W = 16, GB_LANES = 4, GB_IN_UNITS = 4, GB_OUT_UNITS = 3, GB_BUF_UNITS = 9.
  - The count type, 4 bits.
- Sub-module gearbox_64_48: one lane's 144-bit buffer, shift/insert logic and 48-bit output register. It is driven by accept, emit and count from the top. Four instances.
- Top: count register, out_idle/accept/emit logic, out_datavalid and overflow registers.

## Test plan
- Reset/basic:
  - Stimulus: in_enable=1, in_idle=0. Send W0, W1, W2 on consecutive non-idle cycles. Lane 0 values are 64'h3333_2222_1111_0000, 64'h7777_6666_5555_4444, 64'hBBBB_AAAA_9999_8888.
  - Required response: lane 0 outputs 48'h2222_1111_0000, 48'h5555_4444_3333, 48'h8888_7777_6666, 48'hBBBB_AAAA_9999. First valid is 2 cycles after W0.
- Continuous traffic:
  - Stimulus: source always offers data, obeying out_idle, for 400 cycles. Check with a scoreboard against the inverse of the 192→256 lane mapping.
  - Required response: out_idle pattern is 1 in 4; out_datavalid stays high after fill; zero mismatches.
- Backpressure:
  - Stimulus: in_idle high for 5 cycles mid-stream.
  - Required response: count ≤ 9; out_idle high while count > 5; no lost or duplicated units; output resumes 1 cycle after in_idle falls.
- Protocol violation:
  - Stimulus: assert in_datavalid while out_idle is high.
  - Required response: overflow pulses once; that word is absent from the output; subsequent data is intact.
- in_enable low:
  - Stimulus: drop in_enable for 3 cycles with count=5.
  - Required response: out_idle high; out_datavalid low; count stays 5; the stream continues correctly after re-enable.
- Reset mid-stream:
  - Stimulus: assert reset_n low with count=6.
  - Required response: all outputs take their reset values immediately. After release, W0 lane 0 = 64'hDDDD_CCCC_BBBB_AAAA; with W1 the first output is 48'hCCCC_BBBB_AAAA.

Source files
------------

// File: rtl/gearbox_256_192_pkg.sv
// Shared constants and types for the 256->192 receive gearbox.
// Every lane uses the same unit widths and the same shared count.
package gearbox_256_192_pkg;

    localparam int GB_UNIT_W    = 16;
    localparam int GB_LANES     = 4;
    localparam int GB_IN_UNITS  = 4;
    localparam int GB_OUT_UNITS = 3;
    localparam int GB_BUF_UNITS = 9;

    localparam int GB_LANE_IN_W  = GB_UNIT_W * GB_IN_UNITS;
    localparam int GB_LANE_OUT_W = GB_UNIT_W * GB_OUT_UNITS;
    localparam int GB_BUF_W      = GB_UNIT_W * GB_BUF_UNITS;
    localparam int GB_IN_W       = GB_LANE_IN_W * GB_LANES;
    localparam int GB_OUT_W      = GB_LANE_OUT_W * GB_LANES;

    typedef logic [3:0] gb_count_t;

    // A new word fits only while at most this many units are buffered.
    localparam gb_count_t GB_ACCEPT_MAX = gb_count_t'(GB_BUF_UNITS - GB_IN_UNITS);
    localparam gb_count_t GB_EMIT_MIN   = gb_count_t'(GB_OUT_UNITS);

endpackage

// File: rtl/gearbox_64_48.sv
// One 64->48 lane: 9-unit buffer with shift-out of 3 units and insert of 4.
// Controlled entirely by accept/emit/count from the shared top-level controller.
module gearbox_64_48
    import gearbox_256_192_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     accept,
    input  logic                     emit,
    input  gb_count_t                count,
    input  logic [GB_LANE_IN_W-1:0]  in_lane,
    output logic [GB_LANE_OUT_W-1:0] out_lane
);

    logic [GB_BUF_W-1:0] buf_q;
    logic [GB_BUF_W-1:0] buf_d;
    logic [GB_BUF_W-1:0] shifted;
    logic [GB_BUF_W-1:0] ins;
    logic [GB_BUF_W-1:0] mask;
    gb_count_t           wr_idx;

    // NOTE: every signal gets a value before any condition, so no latch can be inferred.
    always_comb begin
        shifted = emit ? (buf_q >> GB_LANE_OUT_W) : buf_q;
        // The insert position is taken after the emit shift.
        wr_idx  = count - (emit ? GB_EMIT_MIN : gb_count_t'(0));
        ins     = {{(GB_BUF_W - GB_LANE_IN_W){1'b0}}, in_lane} << (int'(wr_idx) * GB_UNIT_W);
        mask    = {{(GB_BUF_W - GB_LANE_IN_W){1'b0}}, {GB_LANE_IN_W{1'b1}}} << (int'(wr_idx) * GB_UNIT_W);
        buf_d   = accept ? ((shifted & ~mask) | ins) : shifted;
    end

    // NOTE: the buffer is reset so a mid-stream reset leaves no stale units behind.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q    <= '0;
            out_lane <= '0;
        end else begin
            buf_q <= buf_d;
            if (emit) begin
                out_lane <= buf_q[GB_LANE_OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/gearbox_256_192.sv
// Receive-side 4:3 gearbox: four 64->48 lanes sharing one count and handshake.
// out_idle depends only on the registered count and in_enable.
module gearbox_256_192
    import gearbox_256_192_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_enable,
    input  logic [GB_IN_W-1:0]  in_data,
    input  logic                in_datavalid,
    output logic                out_idle,
    output logic [GB_OUT_W-1:0] out_data,
    output logic                out_datavalid,
    input  logic                in_idle,
    output logic                overflow
);

    gb_count_t count;
    gb_count_t count_next;
    logic      accept;
    logic      emit;

    always_comb begin
        out_idle   = !in_enable || (count > GB_ACCEPT_MAX);
        accept     = in_enable && in_datavalid && !out_idle;
        emit       = in_enable && !in_idle && (count >= GB_EMIT_MIN);
        count_next = count - (emit ? GB_EMIT_MIN : gb_count_t'(0))
                           + (accept ? gb_count_t'(GB_IN_UNITS) : gb_count_t'(0));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            out_datavalid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            count         <= count_next;
            out_datavalid <= emit;
            // A word offered while idle is dropped; flag it for one cycle.
            overflow      <= in_datavalid && out_idle;
        end
    end

    for (genvar k = 0; k < GB_LANES; k++) begin : g_lane
        gearbox_64_48 u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .accept   (accept),
            .emit     (emit),
            .count    (count),
            .in_lane  (in_data[k*GB_LANE_IN_W +: GB_LANE_IN_W]),
            .out_lane (out_data[k*GB_LANE_OUT_W +: GB_LANE_OUT_W])
        );
    end

endmodule

// File: tb/tb_gearbox_256_192.sv
// Directed bench for gearbox_256_192: hand-computed lane-0 vectors plus a
// unit-queue scoreboard covering streaming, backpressure, overflow, enable and reset.
module tb_gearbox_256_192;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_enable;
    logic [255:0] in_data;
    logic         in_datavalid;
    logic         out_idle;
    logic [191:0] out_data;
    logic         out_datavalid;
    logic         in_idle;
    logic         overflow;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int word_no       = 0;

    // Scoreboard: each entry is one unit position across all 4 lanes (lane k at [16k+15:16k]).
    logic [63:0]  uq[$];
    logic         exp_dv;
    logic [191:0] exp_data;
    logic         exp_ovf;

    gearbox_256_192 dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_enable     (in_enable),
        .in_data       (in_data),
        .in_datavalid  (in_datavalid),
        .out_idle      (out_idle),
        .out_data      (out_data),
        .out_datavalid (out_datavalid),
        .in_idle       (in_idle),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] make_word(input int n);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                w[64*k + 16*j +: 16] = {4'(k + 1), 12'(n * 4 + j)};
        return w;
    endfunction

    function automatic logic [255:0] basic_word(input logic [63:0] l0);
        return {l0 ^ {4{16'h3030}}, l0 ^ {4{16'h2020}}, l0 ^ {4{16'h1010}}, l0};
    endfunction

    task automatic model_reset();
        uq.delete();
        exp_dv   = 1'b0;
        exp_data = '0;
        exp_ovf  = 1'b0;
    endtask

    // One clock interval: drive, check registered outputs at negedge, advance the model.
    task automatic cycle(input logic en, input logic want_dv, input logic idle,
                         input logic obey, input logic [255:0] w);
        logic        dv;
        logic        exp_idle;
        logic        emit;
        logic        acc;
        logic [63:0] e;
        exp_idle     = !en || (uq.size() > 5);
        dv           = want_dv && !(obey && exp_idle);
        in_enable    = en;
        in_datavalid = dv;
        in_data      = w;
        in_idle      = idle;
        @(negedge clk);
        check("out_idle", 192'(out_idle), 192'(exp_idle));
        check("count", 192'(dut.count), 192'(uq.size()));
        check("out_datavalid", 192'(out_datavalid), 192'(exp_dv));
        check("out_data", out_data, exp_data);
        check("overflow", 192'(overflow), 192'(exp_ovf));
        emit    = en && !idle && (uq.size() >= 3);
        acc     = en && dv && !exp_idle;
        exp_ovf = dv && exp_idle;
        exp_dv  = emit;
        if (emit) begin
            for (int j = 0; j < 3; j++) begin
                e = uq.pop_front();
                for (int k = 0; k < 4; k++) exp_data[48*k + 16*j +: 16] = e[16*k +: 16];
            end
        end
        if (acc) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) e[16*k +: 16] = w[64*k + 16*j +: 16];
                uq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input logic idle);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b1, idle, 1'b1, make_word(word_no));
            word_no++;
        end
    endtask

    task automatic stream_until(input string tag, input int target);
        for (int i = 0; i < 8 && uq.size() != target; i++) stream(1, 1'b0);
        check(tag, 192'(dut.count), 192'(target));
    endtask

    initial begin
        reset_n      = 1'b0;
        in_enable    = 1'b0;
        in_data      = '0;
        in_datavalid = 1'b0;
        in_idle      = 1'b0;
        model_reset();
        #12;
        check("rst_idle_disabled", 192'(out_idle), 192'(1));
        in_enable = 1'b1;
        #1;
        check("rst_idle_enabled", 192'(out_idle), 192'(0));
        check("rst_datavalid", 192'(out_datavalid), 192'(0));
        check("rst_data", out_data, 192'(0));
        check("rst_overflow", 192'(overflow), 192'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic: three hand-computed words on lane 0.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, basic_word(64'h3333_2222_1111_0000));
        check("basic_no_early_valid", 192'(out_datavalid), 192'(0));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, basic_word(64'h7777_6666_5555_4444));
        check("basic_first_valid", 192'(out_datavalid), 192'(1));
        check("basic_out0", 192'(out_data[47:0]), 192'(48'h2222_1111_0000));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, basic_word(64'hBBBB_AAAA_9999_8888));
        check("basic_out1", 192'(out_data[47:0]), 192'(48'h5555_4444_3333));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        check("basic_out2", 192'(out_data[47:0]), 192'(48'h8888_7777_6666));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        check("basic_out3", 192'(out_data[47:0]), 192'(48'hBBBB_AAAA_9999));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Continuous traffic.
        stream(400, 1'b0);

        // Backpressure from the sink, then resume.
        stream(5, 1'b1);
        check("bp_count_full", 192'(dut.count > 4'd9), 192'(0));
        stream(1, 1'b0);
        check("bp_resume", 192'(out_datavalid), 192'(1));
        stream(20, 1'b0);

        // Protocol violation: offer a word while out_idle is high.
        stream_until("ovf_reach_count6", 6);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, make_word(word_no));
        word_no++;
        check("ovf_pulse", 192'(overflow), 192'(1));
        stream(20, 1'b0);

        // in_enable low with count 5.
        stream_until("en_reach_count5", 5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, make_word(word_no));
        check("en_count_held", 192'(dut.count), 192'(5));
        stream(20, 1'b0);

        // Reset mid-stream at count 6.
        stream_until("rst_reach_count6", 6);
        in_datavalid = 1'b0;
        reset_n      = 1'b0;
        #1;
        check("mid_rst_datavalid", 192'(out_datavalid), 192'(0));
        check("mid_rst_data", out_data, 192'(0));
        check("mid_rst_overflow", 192'(overflow), 192'(0));
        check("mid_rst_idle", 192'(out_idle), 192'(0));
        check("mid_rst_count", 192'(dut.count), 192'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, basic_word(64'hDDDD_CCCC_BBBB_AAAA));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, basic_word(64'h1111_0000_FFFF_EEEE));
        check("realign_out0", 192'(out_data[47:0]), 192'(48'hCCCC_BBBB_AAAA));
        stream(12, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
